fetch_unit: RTL and testbench

//  Parametrised instruction-fetch front end for the Riscv151 pipeline. Owns the PC, issues word reads to
//  the BIOS and IMEM synchronous-read memories, and selects the source by PC[PC_SEL_BIT].

---
 rtl/fetch_unit_pkg.sv | 29 ++
 rtl/fetch_queue.sv | 79 +++++++
 rtl/fetch_unit.sv | 141 ++++++++++++++
 tb/tb_fetch_unit.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// ============================================================================
//  Module      : fetch_unit_pkg
//  Description : Shared constants, entry type and helpers for the Riscv151
//                instruction-fetch front end.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fetch_unit_pkg;

    localparam int          XLEN               = 32;
    localparam logic [31:0] RESET_PC_DEFAULT   = 32'h4000_0000;
    localparam logic [31:0] INST_NOP           = 32'h0000_0013;
    localparam int          PC_SEL_BIT_DEFAULT = 30;

    // One fetch-queue entry: instruction together with the PC it came from
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } fetch_entry_t;

    // Sequential successor of a word-aligned PC (wraps modulo 2^32)
    function automatic logic [XLEN-1:0] next_pc(input logic [XLEN-1:0] pc);
        return pc + XLEN'(4);
    endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_queue.sv
// ============================================================================
//  Module      : fetch_queue
//  Description : DEPTH-entry synchronous FIFO of {pc, inst} pairs with
//                push/pop/clear. No fall-through: a pushed entry is visible
//                the cycle after the push. Clear wins over push and pop.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_queue
    import fetch_unit_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,        // asynchronous, active-low
    input  logic                     clear,
    input  logic                     push,
    input  fetch_entry_t             push_data,
    input  logic                     pop,
    output fetch_entry_t             head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    fetch_entry_t    mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic            do_push;
    logic            do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    // A push into a full queue is only legal when the head leaves in the same cycle
    assign do_push = push & ~clear & (~full | pop);
    assign do_pop  = pop  & ~clear & ~empty;

    // Head is forced to zero while empty so the outputs are clean after reset
    assign head    = empty ? '0 : mem[rd_ptr];

    // Entry storage needs no reset: occupancy is tracked by count
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH is 2^n)
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/fetch_unit.sv
// ============================================================================
//  Module      : fetch_unit
//  Description : Instruction-fetch front end. Owns the PC, issues word reads
//                to the BIOS and IMEM synchronous memories (source chosen by
//                PC[PC_SEL_BIT]) and buffers {pc, inst} pairs for decode.
//                Handles stall, drain and execute-stage redirect with kill of
//                the in-flight read.
//                Optional macro FETCH_PERF_EN adds push/redirect counters.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = RESET_PC_DEFAULT,
    parameter int          DEPTH       = 4,
    parameter int          BIOS_AWIDTH = 12,
    parameter int          IMEM_AWIDTH = 14,
    parameter int          PC_SEL_BIT  = PC_SEL_BIT_DEFAULT
) (
    input  logic                    clk,
    input  logic                    rst,            // asynchronous, active-low
    input  logic                    fetch_en,
    input  logic                    redirect_valid,
    input  logic [31:0]             redirect_pc,
    output logic [BIOS_AWIDTH-1:0]  bios_addr,
    output logic [IMEM_AWIDTH-1:0]  imem_addr,
    output logic                    mem_rd_en,
    input  logic [31:0]             bios_dout,
    input  logic [31:0]             imem_dout,
    output logic                    inst_valid,
    input  logic                    inst_ready,
    output logic [31:0]             inst,
    output logic [31:0]             inst_pc
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]             fetch_count,
    output logic [31:0]             flush_count
`endif
);

    localparam int          CW      = $clog2(DEPTH) + 1;
    localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

    logic [31:0]   pc_q;
    logic          inflight;
    logic [31:0]   resp_pc;
    logic          resp_sel;

    logic [31:0]   fetch_pc;
    logic          pop;
    logic          push;
    logic          issue;
    logic          has_room;
    logic [CW:0]   occupancy;
    logic [CW-1:0] q_count;
    logic          q_full;
    logic          q_empty;
    fetch_entry_t  q_head;
    fetch_entry_t  push_data;

    // Redirect target replaces the sequential PC in the very cycle it arrives
    assign fetch_pc  = redirect_valid ? (redirect_pc & ~32'd3) : pc_q;
    assign bios_addr = fetch_pc[BIOS_AWIDTH+1:2];
    assign imem_addr = fetch_pc[IMEM_AWIDTH+1:2];

    // Queue entries plus the read still in flight must never exceed DEPTH
    assign occupancy = {1'b0, q_count} + {{CW{1'b0}}, inflight};
    assign has_room  = (occupancy < DEPTH_W);

    assign pop       = inst_valid & inst_ready & ~redirect_valid;
    // Gated with rst so no read is reported while reset is held
    assign issue     = rst & (redirect_valid | (fetch_en & (has_room | pop)));
    assign mem_rd_en = issue;

    // A response landing in a redirect cycle belongs to the killed path
    assign push           = inflight & ~redirect_valid;
    assign push_data.pc   = resp_pc;
    assign push_data.inst = resp_sel ? bios_dout : imem_dout;

    assign inst_valid = ~q_empty;
    assign inst       = q_head.inst;
    assign inst_pc    = q_head.pc;

    fetch_queue #(
        .DEPTH      (DEPTH)
    ) u_queue (
        .clk        (clk),
        .rst        (rst),
        .clear      (redirect_valid),
        .push       (push),
        .push_data  (push_data),
        .pop        (pop),
        .head       (q_head),
        .count      (q_count),
        .full       (q_full),
        .empty      (q_empty)
    );

    // PC and in-flight response tracking
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q     <= RESET_PC;
            inflight <= 1'b0;
            resp_pc  <= '0;
            resp_sel <= 1'b0;
        end else begin
            inflight <= issue;
            if (issue) begin
                pc_q     <= next_pc(fetch_pc);
                resp_pc  <= fetch_pc;
                resp_sel <= fetch_pc[PC_SEL_BIT];
            end
        end
    end

`ifdef FETCH_PERF_EN
    // Event counters: queue pushes and redirects, free-running with wrap
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_count <= '0;
            flush_count <= '0;
        end else begin
            if (push) begin
                fetch_count <= fetch_count + 32'd1;
            end
            if (redirect_valid) begin
                flush_count <= flush_count + 32'd1;
            end
        end
    end
`endif

    // q_full only matters inside the queue; keep it observable for lint
    logic unused_ok;
    assign unused_ok = q_full;

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// ============================================================================
//  Module      : tb_fetch_unit
//  Description : Directed self-checking bench for fetch_unit with behavioural
//                BIOS/IMEM synchronous-read models.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_en;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [11:0] bios_addr;
    logic [13:0] imem_addr;
    logic        mem_rd_en;
    logic [31:0] bios_dout;
    logic [31:0] imem_dout;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
`ifdef FETCH_PERF_EN
    logic [31:0] fetch_count;
    logic [31:0] flush_count;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk            (clk),
        .rst            (rst),
        .fetch_en       (fetch_en),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .bios_addr      (bios_addr),
        .imem_addr      (imem_addr),
        .mem_rd_en      (mem_rd_en),
        .bios_dout      (bios_dout),
        .imem_dout      (imem_dout),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc)
`ifdef FETCH_PERF_EN
        ,
        .fetch_count    (fetch_count),
        .flush_count    (flush_count)
`endif
    );

    // Memory contents tag the source and the word address
    function automatic logic [31:0] exp_inst(input logic [31:0] pc);
        if (pc[30]) return 32'hB000_0000 | {20'b0, pc[13:2]};
        else        return 32'hA000_0000 | {18'b0, pc[15:2]};
    endfunction

    // Synchronous-read memory models: data one cycle after the address
    always @(posedge clk) begin
        if (mem_rd_en) begin
            bios_dout <= 32'hB000_0000 | {20'b0, bios_addr};
            imem_dout <= 32'hA000_0000 | {18'b0, imem_addr};
        end
    end

    // Hold reset for two cycles, then release at a falling edge (cycle 0)
    task automatic do_reset(input logic ready_v);
        rst            = 1'b0;
        fetch_en       = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        inst_ready     = ready_v;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b0; fetch_en = 1'b1; redirect_valid = 1'b0;
        redirect_pc = '0; inst_ready = 1'b1;
        @(negedge clk); #1;
        total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", inst_valid); end
        total++; if (mem_rd_en !== 1'b0) begin bad++; $display("FAIL reset_rd_en got=%b want=0", mem_rd_en); end
        total++; if (inst_pc !== 32'h0) begin bad++; $display("FAIL reset_inst_pc got=%h want=0", inst_pc); end
        total++; if (inst !== 32'h0) begin bad++; $display("FAIL reset_inst got=%h want=0", inst); end
    endtask

    task automatic test_stream;
        logic [31:0] exp_pc;
        do_reset(1'b1);
        total++; if (mem_rd_en !== 1'b1 || bios_addr !== 12'h0) begin bad++; $display("FAIL stream_first_issue got=%b/%h want=1/000", mem_rd_en, bios_addr); end
        @(negedge clk); #1;
        total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL stream_latency got=%b want=0", inst_valid); end
        exp_pc = 32'h4000_0000;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk); #1;
            total++;
            if (inst_valid !== 1'b1 || inst_pc !== exp_pc || inst !== exp_inst(exp_pc)) begin
                bad++; $display("FAIL stream_%0d got=%b/%h/%h want=1/%h/%h", i, inst_valid, inst_pc, inst, exp_pc, exp_inst(exp_pc));
            end
            exp_pc = exp_pc + 32'd4;
        end
    endtask

    task automatic test_backpressure;
        logic [31:0] exp_pc;
        do_reset(1'b0);
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk); #1;
            if (i >= 4) begin
                total++; if (mem_rd_en !== 1'b0) begin bad++; $display("FAIL full_no_issue_c%0d got=%b want=0", i, mem_rd_en); end
            end
        end
        // Drain with issue halted: exactly DEPTH entries must come out
        exp_pc = 32'h4000_0000;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            inst_ready = 1'b1; fetch_en = 1'b0; #1;
            total++;
            if (inst_valid !== 1'b1 || inst_pc !== exp_pc || inst !== exp_inst(exp_pc)) begin
                bad++; $display("FAIL drain_%0d got=%b/%h/%h want=1/%h/%h", i, inst_valid, inst_pc, inst, exp_pc, exp_inst(exp_pc));
            end
            exp_pc = exp_pc + 32'd4;
        end
        @(negedge clk); #1;
        total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL drain_empty got=%b want=0", inst_valid); end
    endtask

    task automatic test_redirect_full;
        logic [31:0] exp_pc;
        do_reset(1'b0);
        repeat (4) @(negedge clk);
        redirect_valid = 1'b1; redirect_pc = 32'h1000_0002; #1;
        total++; if (mem_rd_en !== 1'b1 || imem_addr !== 14'h0) begin bad++; $display("FAIL redir_issue got=%b/%h want=1/0000", mem_rd_en, imem_addr); end
        @(negedge clk);
        redirect_valid = 1'b0; #1;
        total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL redir_flushed got=%b want=0", inst_valid); end
        exp_pc = 32'h1000_0000;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            inst_ready = 1'b1; #1;
            total++;
            if (inst_valid !== 1'b1 || inst_pc !== exp_pc || inst !== exp_inst(exp_pc)) begin
                bad++; $display("FAIL redir_target_%0d got=%b/%h/%h want=1/%h/%h", i, inst_valid, inst_pc, inst, exp_pc, exp_inst(exp_pc));
            end
            exp_pc = exp_pc + 32'd4;
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] exp_pc;
        do_reset(1'b1);
        repeat (3) @(negedge clk);
        // Redirect A in a cycle where decode is also popping
        @(negedge clk);
        redirect_valid = 1'b1; redirect_pc = 32'h2000_0000; #1;
        total++; if (inst_valid !== 1'b1 || inst_pc !== 32'h4000_0008) begin bad++; $display("FAIL b2b_pre got=%b/%h want=1/40000008", inst_valid, inst_pc); end
        @(negedge clk);
        redirect_pc = 32'h3000_0100; #1;
        total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL b2b_kill_old got=%b want=0", inst_valid); end
        @(negedge clk);
        redirect_valid = 1'b0; #1;
        total++; if (inst_valid !== 1'b0) begin bad++; $display("FAIL b2b_kill_a got=%b want=0", inst_valid); end
        exp_pc = 32'h3000_0100;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            total++;
            if (inst_valid !== 1'b1 || inst_pc !== exp_pc || inst !== exp_inst(exp_pc)) begin
                bad++; $display("FAIL b2b_target_%0d got=%b/%h/%h want=1/%h/%h", i, inst_valid, inst_pc, inst, exp_pc, exp_inst(exp_pc));
            end
            exp_pc = exp_pc + 32'd4;
        end
`ifdef FETCH_PERF_EN
        total++; if (flush_count !== 32'd2) begin bad++; $display("FAIL b2b_flush_count got=%0d want=2", flush_count); end
`endif
    endtask

    task automatic test_fetch_en;
        do_reset(1'b1);
        repeat (2) @(negedge clk);
        @(negedge clk);
        fetch_en = 1'b0; #1;
        total++; if (inst_pc !== 32'h4000_0004) begin bad++; $display("FAIL halt_head got=%h want=40000004", inst_pc); end
        @(negedge clk); #1;
        total++; if (inst_valid !== 1'b1 || inst_pc !== 32'h4000_0008 || mem_rd_en !== 1'b0) begin
            bad++; $display("FAIL halt_inflight got=%b/%h/%b want=1/40000008/0", inst_valid, inst_pc, mem_rd_en);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            total++; if (inst_valid !== 1'b0 || mem_rd_en !== 1'b0) begin bad++; $display("FAIL halt_idle_%0d got=%b/%b want=0/0", i, inst_valid, mem_rd_en); end
        end
        @(negedge clk);
        fetch_en = 1'b1; #1;
        total++; if (mem_rd_en !== 1'b1 || bios_addr !== 12'h003) begin bad++; $display("FAIL resume_issue got=%b/%h want=1/003", mem_rd_en, bios_addr); end
        repeat (2) @(negedge clk); #1;
        total++; if (inst_valid !== 1'b1 || inst_pc !== 32'h4000_000C || inst !== 32'hB000_0003) begin
            bad++; $display("FAIL resume_data got=%b/%h/%h want=1/4000000c/b0000003", inst_valid, inst_pc, inst);
        end
    endtask

    task automatic test_reset_pulse;
        do_reset(1'b1);
        repeat (4) @(negedge clk); #1;
`ifdef FETCH_PERF_EN
        total++; if (fetch_count !== 32'd3 || flush_count !== 32'd0) begin bad++; $display("FAIL perf_pre got=%0d/%0d want=3/0", fetch_count, flush_count); end
`endif
        rst = 1'b0; #1;
        total++; if (inst_valid !== 1'b0 || mem_rd_en !== 1'b0 || inst_pc !== 32'h0) begin
            bad++; $display("FAIL rst_pulse got=%b/%b/%h want=0/0/0", inst_valid, mem_rd_en, inst_pc);
        end
`ifdef FETCH_PERF_EN
        total++; if (fetch_count !== 32'd0 || flush_count !== 32'd0) begin bad++; $display("FAIL perf_rst got=%0d/%0d want=0/0", fetch_count, flush_count); end
`endif
        @(negedge clk);
        rst = 1'b1; #1;
        total++; if (mem_rd_en !== 1'b1 || bios_addr !== 12'h0) begin bad++; $display("FAIL rst_restart got=%b/%h want=1/000", mem_rd_en, bios_addr); end
        repeat (2) @(negedge clk); #1;
        total++; if (inst_valid !== 1'b1 || inst_pc !== 32'h4000_0000 || inst !== 32'hB000_0000) begin
            bad++; $display("FAIL rst_first got=%b/%h/%h want=1/40000000/b0000000", inst_valid, inst_pc, inst);
        end
    endtask

    initial begin
        rst = 1'b0; fetch_en = 1'b0; redirect_valid = 1'b0;
        redirect_pc = '0; inst_ready = 1'b0;
        test_reset;
        test_stream;
        test_backpressure;
        test_redirect_full;
        test_back_to_back;
        test_fetch_en;
        test_reset_pulse;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
